// File: rtl/fc_tx_credit_arbiter_if.sv
// Bundle between TLP source queues / TX datapath and the flow-control credit arbiter.
// The slave modport is the arbiter's view; master is the traffic source and link side.
interface fc_tx_credit_arbiter_if #(
    parameter int unsigned HDR_CW  = 8,
    parameter int unsigned DATA_CW = 12,
    parameter int unsigned LEN_W   = 10
);
    logic                 fc_init_done;
    logic [HDR_CW-1:0]    ph_limit;
    logic [DATA_CW-1:0]   pd_limit;
    logic [HDR_CW-1:0]    nph_limit;
    logic [DATA_CW-1:0]   npd_limit;
    logic [HDR_CW-1:0]    cplh_limit;
    logic [DATA_CW-1:0]   cpld_limit;
    logic [2:0]           req;
    logic [3*LEN_W-1:0]   req_dcred;
    logic                 tlp_done;
    logic [2:0]           grant;
    logic                 busy;
    logic [HDR_CW-1:0]    ph_consumed;
    logic [DATA_CW-1:0]   pd_consumed;
    logic [HDR_CW-1:0]    nph_consumed;
    logic [DATA_CW-1:0]   npd_consumed;
    logic [HDR_CW-1:0]    cplh_consumed;
    logic [DATA_CW-1:0]   cpld_consumed;

    modport master (
        output fc_init_done, ph_limit, pd_limit, nph_limit, npd_limit, cplh_limit, cpld_limit,
        output req, req_dcred, tlp_done,
        input  grant, busy, ph_consumed, pd_consumed, nph_consumed, npd_consumed,
        input  cplh_consumed, cpld_consumed
    );

    modport slave (
        input  fc_init_done, ph_limit, pd_limit, nph_limit, npd_limit, cplh_limit, cpld_limit,
        input  req, req_dcred, tlp_done,
        output grant, busy, ph_consumed, pd_consumed, nph_consumed, npd_consumed,
        output cplh_consumed, cpld_consumed
    );
endinterface

// File: rtl/fc_tx_credit_arbiter.sv
// TX flow-control scheduler: round-robin over Posted/Non-Posted/Completion requesters,
// granting only when header and data credits pass the modular limit check.
module fc_tx_credit_arbiter #(
    parameter int unsigned HDR_CW  = 8,
    parameter int unsigned DATA_CW = 12,
    parameter int unsigned LEN_W   = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fc_tx_credit_arbiter_if.slave   bus
);
    localparam int unsigned N_REQ = 3;
    localparam logic [HDR_CW-1:0]  HDR_HALF  = HDR_CW'(1) << (HDR_CW - 1);
    localparam logic [DATA_CW-1:0] DATA_HALF = DATA_CW'(1) << (DATA_CW - 1);

    typedef enum logic [1:0] {IDLE, CHECK, GRANT} state_e;

    state_e               state_q, state_d;
    logic [N_REQ-1:0]     elig_q, elig_d, elig_c, elig_live_c;
    logic [1:0]           rr_q, rr_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic                 busy_q;
    logic [HDR_CW-1:0]    hdr_cons_q [N_REQ];
    logic [HDR_CW-1:0]    hdr_cons_d [N_REQ];
    logic [DATA_CW-1:0]   data_cons_q [N_REQ];
    logic [DATA_CW-1:0]   data_cons_d [N_REQ];
    logic [HDR_CW-1:0]    hdr_lim [N_REQ];
    logic [DATA_CW-1:0]   data_lim [N_REQ];
    logic [LEN_W-1:0]     dcred [N_REQ];
    logic [HDR_CW-1:0]    hdr_diff_c [N_REQ];
    logic [DATA_CW-1:0]   data_diff_c [N_REQ];
    logic                 win_found_c;
    logic [1:0]           win_idx_c;

    assign hdr_lim[0]  = bus.ph_limit;
    assign hdr_lim[1]  = bus.nph_limit;
    assign hdr_lim[2]  = bus.cplh_limit;
    assign data_lim[0] = bus.pd_limit;
    assign data_lim[1] = bus.npd_limit;
    assign data_lim[2] = bus.cpld_limit;

    // Modular credit gating: remaining window must not exceed half the counter range.
    always_comb begin
        elig_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            dcred[i]       = bus.req_dcred[i*LEN_W +: LEN_W];
            hdr_diff_c[i]  = hdr_lim[i] - (hdr_cons_q[i] + HDR_CW'(1));
            data_diff_c[i] = data_lim[i] - (data_cons_q[i] + DATA_CW'(dcred[i]));
            elig_c[i]      = bus.req[i] && bus.fc_init_done &&
                             (hdr_diff_c[i] <= HDR_HALF) && (data_diff_c[i] <= DATA_HALF);
        end
    end

    // Round-robin pick; a requester that dropped req after IDLE no longer qualifies.
    always_comb begin
        elig_live_c = elig_q & bus.req;
        win_found_c = 1'b0;
        win_idx_c   = 2'd0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            int unsigned j;
            j = (int'(rr_q) + k) % N_REQ;
            if (!win_found_c && elig_live_c[j]) begin
                win_found_c = 1'b1;
                win_idx_c   = 2'(j);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        elig_d      = elig_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        hdr_cons_d  = hdr_cons_q;
        data_cons_d = data_cons_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = CHECK;
                    elig_d  = elig_c;
                end
            end
            CHECK: begin
                grant_d = '0;
                if (win_found_c) begin
                    state_d = GRANT;
                    rr_d    = (win_idx_c == 2'd2) ? 2'd0 : win_idx_c + 2'd1;
                    for (int unsigned i = 0; i < N_REQ; i++) begin
                        if (win_idx_c == 2'(i)) begin
                            grant_d[i]     = 1'b1;
                            hdr_cons_d[i]  = hdr_cons_q[i] + HDR_CW'(1);
                            data_cons_d[i] = data_cons_q[i] + DATA_CW'(dcred[i]);
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (bus.tlp_done) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            elig_q  <= '0;
            rr_q    <= 2'd0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                hdr_cons_q[i]  <= '0;
                data_cons_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            elig_q      <= elig_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            busy_q      <= (state_d != IDLE);
            hdr_cons_q  <= hdr_cons_d;
            data_cons_q <= data_cons_d;
        end
    end

    assign bus.grant         = grant_q;
    assign bus.busy          = busy_q;
    assign bus.ph_consumed   = hdr_cons_q[0];
    assign bus.nph_consumed  = hdr_cons_q[1];
    assign bus.cplh_consumed = hdr_cons_q[2];
    assign bus.pd_consumed   = data_cons_q[0];
    assign bus.npd_consumed  = data_cons_q[1];
    assign bus.cpld_consumed = data_cons_q[2];
endmodule
